// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: bus addresses, status bits, TX states.
// Latency: none (constants and types only).
// Backpressure: none.
package uart_pkg;

  localparam logic [31:0] ADDR_DATA = 32'hBFD0_03F8;
  localparam logic [31:0] ADDR_STAT = 32'hBFD0_03FC;

  // Bit positions inside the status word
  localparam int STAT_TXRDY = 0;
  localparam int STAT_RXAV  = 1;
  localparam int STAT_IDLE  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Generic synchronous FIFO with show-ahead read port (pop_dat valid whenever !empty).
// Latency: a push is visible on pop_dat one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; both may occur in one cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];
  // Full/empty use the pre-edge count, so a push into a full FIFO is dropped even alongside a pop
  assign push_ok = push_vld & ~full;
  assign pop_ok  = pop_rdy & ~empty;

  // Next pointer and occupancy values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset discards any stored entries
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// CPU-bus mapped 8N1 serial transmitter with byte FIFO and pollable status register.
// Latency: byte written at edge E into an idle block drives the start bit from edge E+1.
// Backpressure: none on the bus; writes to a full FIFO are dropped and flagged in sticky OVF.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram2_ce_i,
  input  logic        ram2_we_i,
  input  logic [31:0] ram2_addr_i,
  input  logic [31:0] ram2_data_i,
  input  logic [3:0]  ram2_sel_i,
  output logic [31:0] ram2_data_o,
  output logic        hit_o,
  output logic        txd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int FAW = $clog2(FIFO_DEPTH);

  tx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            ovf_q, ovf_d;

  logic            is_data, is_stat, wr_data, stat_rd;
  logic            fifo_pop, fifo_full, fifo_empty, bit_end;
  logic [7:0]      fifo_dat;
  logic [FAW:0]    fifo_count;
  logic [31:0]     status;
  logic            unused_bits;

  assign is_data = (ram2_addr_i == ADDR_DATA);
  assign is_stat = (ram2_addr_i == ADDR_STAT);
  assign hit_o   = ram2_ce_i & (is_data | is_stat);
  assign wr_data = ram2_ce_i & ram2_we_i & is_data & ram2_sel_i[0];
  assign stat_rd = ram2_ce_i & ~ram2_we_i & is_stat;
  assign bit_end = (cnt_q == CW'(DIV - 1));

  // Upper write byte lanes and FIFO occupancy have no consumer in the TX-only block
  assign unused_bits = ^{ram2_sel_i[3:1], ram2_data_i[31:8], fifo_count};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (wr_data),
    .push_dat (ram2_data_i[7:0]),
    .pop_rdy  (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Status word and read mux; DATA reads and misses return zero
  always_comb begin
    status             = '0;
    status[STAT_TXRDY] = ~fifo_full;
    status[STAT_RXAV]  = 1'b0;
    status[STAT_IDLE]  = fifo_empty & (state_q == ST_IDLE);
    status[STAT_OVF]   = ovf_q;
    ram2_data_o        = stat_rd ? status : 32'h0;
  end

  // Sticky overflow: a drop sets it, a STAT read clears it (read returns the old value)
  always_comb begin
    ovf_d = ovf_q;
    if (stat_rd)               ovf_d = 1'b0;
    if (wr_data && fifo_full)  ovf_d = 1'b1;
  end

  // TX FSM next state, baud counter, bit index, FIFO pop and line level
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    txd      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dat;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        txd = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        txd = shift_q[idx_q];
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next frame so back-to-back bytes have no idle gap
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dat;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: scoreboarded frame and status-read monitors, plus a default-rate instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_mmio;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ce, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic [31:0] rdata;
  logic        hit, txd;

  logic        ce2, we2;
  logic [31:0] addr2, wdata2;
  logic [3:0]  sel2;
  logic [31:0] rdata2;
  logic        hit2, txd2;

  uart_tx_mmio #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .ram2_ce_i(ce), .ram2_we_i(we), .ram2_addr_i(addr),
    .ram2_data_i(wdata), .ram2_sel_i(sel), .ram2_data_o(rdata), .hit_o(hit), .txd(txd)
  );

  uart_tx_mmio dut2 (
    .clk(clk), .rst(rst), .ram2_ce_i(ce2), .ram2_we_i(we2), .ram2_addr_i(addr2),
    .ram2_data_i(wdata2), .ram2_sel_i(sel2), .ram2_data_o(rdata2), .hit_o(hit2), .txd(txd2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] b;
    int         start;   // expected start-bit cycle, or -1 for "immediately after previous frame"
  } frame_t;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        h;
  } rd_t;

  frame_t frame_q[$];
  rd_t    rd_q[$];
  int     frames_done = 0;
  bit     mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame monitor: decodes every 160-cycle frame on txd against the expected-frame queue
  initial begin
    logic       prev;
    logic [9:0] fb;
    logic [7:0] rx;
    int         bad, st, last_start;
    frame_t     e;
    prev = 1'b1;
    last_start = 0;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && txd === 1'b0) begin
        st = cyc;
        if (frame_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, expected none", st);
        end else begin
          e   = frame_q.pop_front();
          fb  = {1'b1, e.b, 1'b0};
          bad = 0;
          rx  = '0;
          for (int s = 0; s < 160; s++) begin
            if (s > 0) @(negedge clk);
            if (txd !== fb[s/16]) bad++;
            if ((s % 16) == 8 && s >= 16 && s < 144) rx[s/16 - 1] = txd;
          end
          check("frame_byte", rx, e.b);
          check("frame_levels", bad, 0);
          if (e.start >= 0) check("frame_start_cyc", st, e.start);
          else              check("frame_contiguous", st, last_start + 160);
          last_start = st;
          frames_done++;
        end
      end
      prev = txd;
    end
  end

  // Read monitor: compares every bus read of the main instance against the read queue
  initial begin
    rd_t r;
    forever begin
      @(negedge clk);
      if (ce === 1'b1 && we === 1'b0) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: data 0x%0h with no expectation", rdata);
        end else begin
          r = rd_q.pop_front();
          check({r.name, "_data"}, rdata, r.d);
          check({r.name, "_hit"}, hit, r.h);
        end
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d, input logic [3:0] s,
                           output int k);
    k = cyc;
    ce = 1'b1; we = 1'b1; addr = a; wdata = {24'h0, d}; sel = s;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic h);
    rd_t r;
    r.name = name; r.d = d; r.h = h;
    rd_q.push_back(r);
    ce = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
    @(posedge clk); #1;
    ce = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("frame_wait", frames_done, target);
    #1;
  endtask

  task automatic idle_cycles(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
  endtask

  task automatic run_len(output int n);
    logic lvl;
    lvl = txd2;
    n = 0;
    while (txd2 === lvl && n < 60000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k0, lows, n;
    int exp_runs[5];
    exp_runs = '{5208, 5208, 26040, 5208, 5208};
    rst = 1'b1;
    ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
    ce2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0; sel2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", txd, 1'b1);
    check("reset_txd2", txd2, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    bus_read("stat_after_reset", ADDR_STAT, 32'h5, 1'b1);

    // Single byte 0x55
    bus_write(ADDR_DATA, 8'h55, 4'h1, k);
    frame_q.push_back('{b: 8'h55, start: k + 2});
    wait_frames(1, 400);

    // Two bytes on consecutive cycles: contiguous frames, then idle
    repeat (2) @(posedge clk); #1;
    bus_write(ADDR_DATA, 8'hA3, 4'h1, k);
    frame_q.push_back('{b: 8'hA3, start: k + 2});
    bus_write(ADDR_DATA, 8'h0F, 4'h1, k);
    frame_q.push_back('{b: 8'h0F, start: -1});
    wait_frames(3, 800);
    repeat (2) @(posedge clk); #1;
    bus_read("stat_idle_after_pair", ADDR_STAT, 32'h5, 1'b1);

    // Ten bytes back-to-back: first popped, eight buffered, tenth dropped
    for (int i = 0; i < 10; i++) begin
      bus_write(ADDR_DATA, 8'(8'h10 + i), 4'h1, k);
      if (i == 0)     frame_q.push_back('{b: 8'h10, start: k + 2});
      else if (i < 9) frame_q.push_back('{b: 8'(8'h10 + i), start: -1});
    end
    bus_read("stat_full_ovf", ADDR_STAT, 32'h8, 1'b1);
    bus_read("stat_ovf_cleared", ADDR_STAT, 32'h0, 1'b1);
    wait_frames(12, 2000);

    // Reset during data bit 4 with a second byte still queued
    repeat (3) @(posedge clk); #1;
    mon_en = 1'b0;
    bus_write(ADDR_DATA, 8'hC3, 4'h1, k0);
    bus_write(ADDR_DATA, 8'h3C, 4'h1, k);
    @(negedge clk);
    check("abort_start_bit", txd, 1'b0);
    repeat (85) @(negedge clk);
    check("abort_bit4_level", txd, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_edge_txd", txd, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_read("stat_after_abort", ADDR_STAT, 32'h5, 1'b1);
    mon_en = 1'b1;
    idle_cycles(300, lows);
    check("no_frame_after_reset", lows, 0);

    // Ignored writes and address decode
    @(posedge clk); #1;
    bus_write(ADDR_DATA, 8'h99, 4'b1110, k);
    bus_write(ADDR_STAT, 8'h77, 4'hF, k);
    bus_read("stat_ignored_writes", ADDR_STAT, 32'h5, 1'b1);
    bus_read("rd_data_reg", ADDR_DATA, 32'h0, 1'b1);
    bus_read("rd_miss", 32'h8000_0000, 32'h0, 1'b0);
    idle_cycles(200, lows);
    check("no_frame_ignored", lows, 0);

    // Default rate instance: 0x41 gives runs 1S,1,5,1,1 bit periods, then stop
    @(posedge clk); #1;
    ce2 = 1'b1; we2 = 1'b1; addr2 = ADDR_DATA; wdata2 = 32'h41; sel2 = 4'h1;
    @(posedge clk); #1;
    ce2 = 1'b0; we2 = 1'b0;
    n = 0;
    while (txd2 !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("dflt_start_seen", txd2, 1'b0);
    ce2 = 1'b1; we2 = 1'b0; addr2 = ADDR_STAT;
    for (int r = 0; r < 5; r++) begin
      run_len(n);
      check($sformatf("dflt_run%0d", r), n, exp_runs[r]);
    end
    n = 0;
    while (rdata2[STAT_IDLE] !== 1'b1 && txd2 === 1'b1 && n < 6000) begin
      n++;
      @(negedge clk);
    end
    check("dflt_stop_len", n, 5208);
    ce2 = 1'b0;

    repeat (4) @(posedge clk);
    check("frame_queue_drained", frame_q.size(), 0);
    check("read_queue_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
